// File: rtl/i2s_stereo_tx.sv
// Stereo I2S / left-justified transmitter for the PmodI2S DAC.
// A one-deep holding register takes a left/right pair from the synthesiser
// path. Each frame is serialised MSB-first into two SLOT_W-bit slots, with
// data changing only on SCLK falling edges.
module i2s_stereo_tx #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int MCLK_DIV = 25,
  parameter int SCLK_DIV = 50,
  parameter int I2S_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] l_sample,
  input  logic [DATA_W-1:0] r_sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              sig_out,
  output logic              underrun
);

  localparam int MC_W  = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;
  localparam int SC_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int IDX_W = $clog2(2 * SLOT_W);

  localparam logic [MC_W-1:0]  MC_LAST  = MC_W'(MCLK_DIV - 1);
  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * SLOT_W - 1);
  localparam logic [IDX_W-1:0] IDX_SLOT = IDX_W'(SLOT_W);
  localparam logic [IDX_W-1:0] MODE_P   = IDX_W'(I2S_MODE);
  localparam logic [IDX_W-1:0] DATA_END = IDX_W'(DATA_W + I2S_MODE);

  logic [MC_W-1:0]   mclk_cnt;
  logic [SC_W-1:0]   sclk_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] hold_l, hold_r;
  logic              hold_full;
  logic [DATA_W-1:0] shift_l, shift_r;

  logic              sclk_fall;
  logic              frame_load;
  logic [IDX_W-1:0]  next_idx;
  logic [IDX_W-1:0]  slot_pos;
  logic              next_right;
  logic              in_data;
  logic              next_bit;
  logic [DATA_W-1:0] cur_l, cur_r, cur_s, shifted;

  // Handshake: a pair moves into the hold register on any clk edge where
  // sample_valid && sample_ready. sample_ready is simply "hold empty", so a
  // valid held high while ready is low never causes a duplicate acceptance.
  assign sample_ready = ~hold_full;

  // Next bit position and the bit it emits; a frame load uses the freshly
  // loaded pair for its very first bit.
  always_comb begin
    sclk_fall  = SCLK && (sclk_cnt == SC_LAST);
    next_idx   = (bit_idx == IDX_LAST) ? '0 : bit_idx + IDX_W'(1);
    frame_load = sclk_fall && (next_idx == '0);
    next_right = (next_idx >= IDX_SLOT);
    slot_pos   = next_right ? next_idx - IDX_SLOT : next_idx;
    cur_l      = (frame_load && hold_full) ? hold_l : shift_l;
    cur_r      = (frame_load && hold_full) ? hold_r : shift_r;
    cur_s      = next_right ? cur_r : cur_l;
    in_data    = (slot_pos >= MODE_P) && (slot_pos < DATA_END);
    shifted    = cur_s << (slot_pos - MODE_P);
    next_bit   = in_data & shifted[DATA_W-1];
  end

  // MCLK divider: toggle every MCLK_DIV clk cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      mclk_cnt <= '0;
      MCLK     <= 1'b0;
    end else if (mclk_cnt == MC_LAST) begin
      mclk_cnt <= '0;
      MCLK     <= ~MCLK;
    end else begin
      mclk_cnt <= mclk_cnt + MC_W'(1);
    end
  end

  // SCLK divider: toggle every SCLK_DIV clk cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_cnt <= '0;
      SCLK     <= 1'b0;
    end else if (sclk_cnt == SC_LAST) begin
      sclk_cnt <= '0;
      SCLK     <= ~SCLK;
    end else begin
      sclk_cnt <= sclk_cnt + SC_W'(1);
    end
  end

  // Serialiser: advance position, LRCLK and data on each SCLK falling edge;
  // at the frame start load the held pair or repeat the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx  <= IDX_LAST;
      LRCLK    <= 1'b0;
      sig_out  <= 1'b0;
      shift_l  <= '0;
      shift_r  <= '0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (sclk_fall) begin
        bit_idx <= next_idx;
        LRCLK   <= next_right;
        sig_out <= next_bit;
        if (frame_load) begin
          if (hold_full) begin
            shift_l <= hold_l;
            shift_r <= hold_r;
          end else begin
            underrun <= 1'b1;
          end
        end
      end
    end
  end

  // Holding register: accept only while empty; the frame load drains it.
  // Acceptance and load are exclusive because one needs empty, the other full.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else if (sample_valid && !hold_full) begin
      hold_l    <= l_sample;
      hold_r    <= r_sample;
      hold_full <= 1'b1;
    end else if (frame_load && hold_full) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: doc/i2s_stereo_tx.md
Name: i2s_stereo_tx

Overview:
Parametrised stereo I2S / left-justified transmitter that drives the PmodI2S DAC from the synthesiser output path.
- Accepts a left/right sample pair over a valid/ready handshake into a one-deep holding register.
- Generates MCLK, SCLK and LRCLK from the system clock and serialises both channels MSB-first.
- Adds what the previous output block lacked: a synchronous reset, independent per-channel samples, configurable word and slot widths, mode selection, and underrun reporting.

Parameters:
DATA_W, 16, sample width in bits per channel
SLOT_W, 32, SCLK periods per channel slot; must satisfy SLOT_W >= DATA_W + I2S_MODE
MCLK_DIV, 25, clk cycles per MCLK half-period
SCLK_DIV, 50, clk cycles per SCLK half-period
I2S_MODE, 1, 1 = I2S (MSB one SCLK after LRCLK edge); 0 = left-justified (MSB coincident with LRCLK edge)

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  synchronous, active-high reset
l_sample  in  DATA_W  left-channel sample, two's complement
r_sample  in  DATA_W  right-channel sample, two's complement
sample_valid  in  1  l_sample/r_sample pair is valid
sample_ready  out  1  holding register empty; pair accepted on a clk edge where valid && ready
MCLK  out  1  master clock to PmodI2S
SCLK  out  1  serial bit clock
LRCLK  out  1  word select: 0 = left slot, 1 = right slot
sig_out  out  1  serial data
underrun  out  1  one-clk pulse when a frame starts with the holding register empty

Behaviour:
Interface: one clock (clk); reset is synchronous and active-high (rst). All outputs are registered.
Reset values:
- MCLK=0, SCLK=0, LRCLK=0, sig_out=0, underrun=0.
- Divider counters=0; hold empty, so sample_ready=1.
- Shift pair = 0; bit_idx = 2*SLOT_W-1.
MCLK:
- Free-running counter 0..MCLK_DIV-1.
- At MCLK_DIV-1, MCLK toggles and the counter returns to 0.
SCLK:
- Same scheme with SCLK_DIV.
- First rise occurs SCLK_DIV clk edges after reset release; first fall occurs 2*SCLK_DIV edges after.
Falling-edge update (clk edge where SCLK goes 1->0):
- next = (bit_idx == 2*SLOT_W-1) ? 0 : bit_idx+1; bit_idx <= next.
- LRCLK <= (next >= SLOT_W).
- p = next mod SLOT_W, d = p - I2S_MODE.
- sig_out <= channel sample bit [DATA_W-1-d] if 0 <= d < DATA_W, else 0. The channel is left if next < SLOT_W, otherwise right.
- Data therefore changes only on SCLK falling edges and is stable across the rising edge.
Frame load (falling edge where next == 0):
- Hold full: copy the hold pair into the shift pair; hold becomes empty, so sample_ready=1 from the next clk.
- Hold empty: keep the previous shift pair (repeat last pair) and assert underrun for exactly that clk. After reset the previous pair is zero, so an underrun outputs silence.
- The bit emitted at next==0 uses the newly loaded pair.
Handshake:
- sample_ready = !hold_full.
- Acceptance and frame load on the same clk with the hold empty: the load sees empty (underrun, repeat), and the accepted pair stays in hold for the next frame.
- Holding a pair while ready=0 has no effect; valid may stay high across cycles without duplicate acceptance.
Reset mid-operation: all state returns to reset values on the next clk edge; a partially sent frame is abandoned and the held pair is discarded.
Timing: one frame = 2*SLOT_W SCLK periods. With the defaults, SCLK = 1 MHz, LRCLK = 15.625 kHz, MCLK = 2 MHz.
Widths: counters sized $clog2 of their range; no arithmetic on sample data.

Test Plan:
1. Reset values: hold rst high for 3 clk -> all outputs 0, sample_ready=1. Release -> SCLK rises at clk edge 50 and falls at edge 100, LRCLK=0; MCLK toggles every 25 clk.
2. I2S mode, single pair (defaults), l=16'hA5C3, r=16'h3C5A, accepted before the first fall:
   - Left slot sig_out per fall: p=0 -> 0; p=1..16 -> 1010010111000011; p=17..31 -> 0.
   - LRCLK rises at p=32; right slot p=33..48 -> 0011110001011010.
   - underrun=0 for frame 0 and 1 for frame 1.
3. Left-justified (I2S_MODE=0), l=16'h8001: LRCLK falls together with sig_out=1 (p=0); p=15 -> 1; p=1..14 and p=16..31 -> 0.
4. Backpressure: offer pairs P1, P2, P3 back-to-back with valid held high:
   - P1 accepted; ready=0; P2 waits.
   - At the frame-0 load ready returns to 1 next clk; P2 accepted; frames carry P1, P2, P3 in order, none dropped or duplicated.
5. Underrun/repeat: send one pair 16'h7FFF/16'h8000, then none -> frames 1..3 repeat 7FFF/8000; underrun pulses one clk at each frame start.
6. Reset mid-frame: assert rst at bit_idx=20 of the left slot:
   - Next clk: all outputs 0, hold empty.
   - After release the timing of test 1 repeats exactly; the discarded pair never appears on sig_out.
